// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: timestamps retired instructions into a first-word fall-through
// queue, counts drops when full, and can freeze capture after the first drop.
module commit_trace_fifo #(
  parameter int DEPTH       = 16,
  parameter bit STOP_ON_OVF = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [31:0]              commit_inst,
  input  logic                     commit_wen,
  input  logic [4:0]               commit_waddr,
  input  logic [31:0]              commit_wdata,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_ts,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_wdata,
  output logic                     out_wen,
  output logic [4:0]               out_waddr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic                     frozen
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;

  state_t        state, state_next;
  logic [31:0]   cycle_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        new_entry;
  logic          pop, push, drop, slot_free;

  // A full FIFO still has room when the head leaves in the same cycle.
  always_comb begin
    pop        = (count != '0) && out_ready;
    slot_free  = (count != FULL_CNT) || pop;
    push       = 1'b0;
    drop       = 1'b0;
    state_next = state;
    if (clear) begin
      state_next = RUN;
    end else if (commit_valid) begin
      if (state == RUN && slot_free) begin
        push = 1'b1;
      end else begin
        drop = 1'b1;
        if (STOP_ON_OVF) state_next = FROZEN;
      end
    end
  end

  // Timestamp is the value the cycle counter takes on the capturing edge.
  always_comb begin
    new_entry.ts    = cycle_cnt + 32'd1;
    new_entry.pc    = commit_pc;
    new_entry.inst  = commit_inst;
    new_entry.wen   = commit_wen;
    new_entry.waddr = commit_waddr;
    new_entry.wdata = commit_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      cycle_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_next;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_ts    = head.ts;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_wen   = head.wen;
  assign out_waddr = head.waddr;
  assign out_wdata = head.wdata;
  assign frozen    = (state == FROZEN);

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: queue-based reference model feeds a scoreboard that a
// negedge monitor drains whenever the DUT presents a head entry.
module tb_commit_trace_fifo;
  localparam int DEPTH = 16;
  localparam bit STOP  = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0, commit_inst = '0, commit_wdata = '0;
  logic        commit_wen = 1'b0;
  logic [4:0]  commit_waddr = '0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_ts, out_pc, out_inst, out_wdata;
  logic        out_wen;
  logic [4:0]  out_waddr;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        frozen;

  always #5 clk = ~clk;

  commit_trace_fifo #(.DEPTH(DEPTH), .STOP_ON_OVF(STOP)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_wen(commit_wen), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_ts(out_ts), .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata),
    .out_wen(out_wen), .out_waddr(out_waddr),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .frozen(frozen)
  );

  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sbq[$];
  exp_t        m_e;
  exp_t        got;
  int          m_count = 0;
  int          m_drop  = 0;
  bit          m_ovf   = 1'b0;
  bit          m_frozen = 1'b0;
  bit          m_pop;
  logic [31:0] tick = '0;
  int          checks = 0;
  int          failures = 0;

  // Reference model: occupancy and flags from the rules, entries into the scoreboard.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_count = 0; m_drop = 0; m_ovf = 1'b0; m_frozen = 1'b0; tick = '0;
      sbq.delete();
    end else begin
      tick  = tick + 32'd1;
      m_pop = (m_count != 0) && out_ready;
      if (clear) begin
        m_count = 0; m_drop = 0; m_ovf = 1'b0; m_frozen = 1'b0;
        sbq.delete();
      end else begin
        if (commit_valid && !m_frozen && (m_count < DEPTH || m_pop)) begin
          m_e = '{ts: tick, pc: commit_pc, inst: commit_inst, wen: commit_wen,
                  waddr: commit_waddr, wdata: commit_wdata};
          sbq.push_back(m_e);
          m_count = m_count + 1;
        end else if (commit_valid) begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop = m_drop + 1;
          if (STOP) m_frozen = 1'b1;
        end
        if (m_pop) m_count = m_count - 1;
      end
    end
  end

  // Monitor: status every cycle, head entry whenever valid, pop on handshake.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ({count, out_valid, overflow, drop_cnt, frozen} !==
          {5'(m_count), (m_count != 0), m_ovf, 16'(m_drop), m_frozen}) begin
        failures++;
        $display("FAIL status t=%0t got cnt=%0d vld=%0b ovf=%0b drop=%0d frz=%0b want cnt=%0d ovf=%0b drop=%0d frz=%0b",
                 $time, count, out_valid, overflow, drop_cnt, frozen, m_count, m_ovf, m_drop, m_frozen);
      end
      if (out_valid) begin
        checks++;
        got = {out_ts, out_pc, out_inst, out_wen, out_waddr, out_wdata};
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL head_unexpected t=%0t got=%h want=none", $time, got);
        end else begin
          if (got !== sbq[0]) begin
            failures++;
            $display("FAIL head_entry t=%0t got=%h want=%h", $time, got, sbq[0]);
          end
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_commit(input bit v);
    commit_valid = v;
    commit_pc    = $urandom;
    commit_inst  = $urandom;
    commit_wen   = 1'($urandom);
    commit_waddr = 5'($urandom);
    commit_wdata = $urandom;
  endtask

  task automatic expect_eq(input string name, input logic [63:0] got_v, input logic [63:0] want);
    checks++;
    if (got_v !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got_v, want);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 64 && count != 0; i++) next_cycle();
    expect_eq("drain_empty", 64'(count), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    expect_eq("rst_count", 64'(count), 64'd0);
    expect_eq("rst_valid", 64'(out_valid), 64'd0);
    expect_eq("rst_ovf", 64'(overflow), 64'd0);
    expect_eq("rst_drop", 64'(drop_cnt), 64'd0);
    expect_eq("rst_frozen", 64'(frozen), 64'd0);
    reset = 1'b1;

    // Single commit captured on the edge that takes the counter to 5, held until accepted.
    repeat (4) next_cycle();
    set_commit(1'b1);
    commit_pc = 32'h0040_0000; commit_inst = 32'h3C01_1001;
    next_cycle();
    commit_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_eq("single_ts", 64'(out_ts), 64'd5);
      expect_eq("single_pc", 64'(out_pc), 64'h0040_0000);
      expect_eq("single_cnt", 64'(count), 64'd1);
      next_cycle();
    end
    out_ready = 1'b1;
    next_cycle();
    expect_eq("single_popped", 64'(count), 64'd0);
    out_ready = 1'b0;

    // 18 back-to-back commits into a 16-deep FIFO: two drops, then frozen.
    for (int i = 0; i < 18; i++) begin
      set_commit(1'b1);
      commit_pc = 32'h1000 + 32'(i * 4);
      next_cycle();
    end
    commit_valid = 1'b0;
    expect_eq("ovf_count", 64'(count), 64'd16);
    expect_eq("ovf_flag", 64'(overflow), 64'd1);
    expect_eq("ovf_frozen", 64'(frozen), 64'd1);
    expect_eq("ovf_drops", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && count != 0; i++) begin
      set_commit(1'($urandom));
      next_cycle();
    end
    commit_valid = 1'b0;
    expect_eq("frozen_drained", 64'(count), 64'd0);
    expect_eq("frozen_stays", 64'(frozen), 64'd1);
    out_ready = 1'b0;

    // Clear while frozen, with a commit in the same cycle that must vanish.
    set_commit(1'b1);
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    commit_valid = 1'b0;
    expect_eq("clr_count", 64'(count), 64'd0);
    expect_eq("clr_ovf", 64'(overflow), 64'd0);
    expect_eq("clr_drop", 64'(drop_cnt), 64'd0);
    expect_eq("clr_frozen", 64'(frozen), 64'd0);
    next_cycle();
    expect_eq("clr_not_stored", 64'(out_valid), 64'd0);

    // Full FIFO with simultaneous push and pop: no drop, new entry goes last.
    for (int i = 0; i < DEPTH; i++) begin
      set_commit(1'b1);
      next_cycle();
    end
    set_commit(1'b1);
    commit_pc = 32'hABCD_0000;
    out_ready = 1'b1;
    next_cycle();
    commit_valid = 1'b0;
    out_ready = 1'b0;
    expect_eq("full_pp_count", 64'(count), 64'd16);
    expect_eq("full_pp_drop", 64'(drop_cnt), 64'd0);
    drain();

    // Continuous streaming exercises pointer wrap with occupancy stuck at 1.
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_commit(1'b1);
      next_cycle();
      expect_eq("stream_count", 64'(count), 64'd1);
    end
    commit_valid = 1'b0;
    drain();

    // Random traffic with varying consumer pressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      set_commit($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 99) < (((i / 50) % 2 == 0) ? 30 : 80));
      clear = ($urandom_range(0, 49) == 0);
      next_cycle();
    end
    commit_valid = 1'b0;
    clear = 1'b0;
    drain();

    // Asynchronous reset mid-stream with seven entries queued.
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_commit(1'b1);
      next_cycle();
    end
    commit_valid = 1'b0;
    expect_eq("pre_rst_count", 64'(count), 64'd7);
    #1 reset = 1'b0;
    #1;
    expect_eq("async_rst_count", 64'(count), 64'd0);
    expect_eq("async_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    set_commit(1'b1);
    next_cycle();
    commit_valid = 1'b0;
    expect_eq("post_rst_ts", 64'(out_ts), 64'd1);
    expect_eq("post_rst_count", 64'(count), 64'd1);
    drain();

    next_cycle();
    expect_eq("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, number of entries (power of two, 4..256); STOP_ON_OVF, 1, 1 = freeze capture after first drop, 0 = keep capturing.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 commit_valid  input  1  CPU retired one instruction this cycle.
REQ-005 commit_pc  input  32  PC of retired instruction.
REQ-006 commit_inst  input  32  instruction word.
REQ-007 commit_wen  input  1  register-file write enable of that instruction.
REQ-008 commit_waddr  input  5  register-file write address.
REQ-009 commit_wdata  input  32  register-file write data.
REQ-010 clear  input  1  synchronous flush request.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  consumer accepts head entry.
REQ-013 out_ts, out_pc, out_inst, out_wdata  output  32 each  head entry fields (timestamp, PC, instruction, write data).
REQ-014 out_wen  output  1; out_waddr  output  5  head entry fields.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 overflow  output  1  sticky: at least one commit dropped since reset/clear.
REQ-017 drop_cnt  output  16  dropped commits, saturating at 0xFFFF.
REQ-018 frozen  output  1  capture FSM in FROZEN state.

Function
REQ-019 A free-running 32-bit cycle counter SHALL increment every clk edge out of reset, wrap 0xFFFFFFFF->0, and be unaffected by clear.
REQ-020 A push SHALL store {counter value at that edge, commit_pc, commit_inst, commit_wen, commit_waddr, commit_wdata}.
REQ-021 Capture FSM SHALL have states RUN and FROZEN; reset and clear enter RUN.
REQ-022 In RUN, commit_valid with a free slot SHALL push.
REQ-023 Free slot SHALL mean count<DEPTH, or count==DEPTH with a pop in the same cycle.
REQ-024 In RUN, commit_valid with no free slot SHALL drop the commit, set overflow, and increment drop_cnt (saturating).
REQ-025 On a drop with STOP_ON_OVF=1, the FSM SHALL go RUN->FROZEN; with STOP_ON_OVF=0 it stays in RUN.
REQ-026 In FROZEN, commit_valid SHALL never push and SHALL increment drop_cnt (saturating); pops continue normally.
REQ-027 FROZEN SHALL be left only by clear or reset.
REQ-028 A pop SHALL occur when out_valid && out_ready; it advances the head pointer.
REQ-029 out_valid SHALL equal (count!=0); out_ready while empty SHALL have no effect.
REQ-030 Output fields SHALL reflect the head entry from storage (first-word fall-through): an entry pushed at edge N is visible with out_valid=1 after edge N, latency 1 cycle.
REQ-031 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-032 Simultaneous push and pop SHALL leave count unchanged.
REQ-033 Read/write pointers SHALL wrap modulo DEPTH.
REQ-034 clear SHALL take priority over push and pop in the same cycle: count=0, pointers=0, overflow=0, drop_cnt=0, FSM=RUN, and the commit in that cycle is discarded without counting as a drop.

Reset
REQ-035 While reset is low: count=0, out_valid=0, overflow=0, drop_cnt=0, frozen=0, FSM=RUN, pointers=0, cycle counter=0.
REQ-036 Reset SHALL take effect immediately (asynchronously), including mid-burst; entry storage contents need not be reset.
REQ-037 The first clk edge after reset deasserts SHALL increment the cycle counter to 1.

Verification
REQ-038 Single commit (pc=0x00400000, inst=0x3C011001) at edge with counter=5, out_ready=0 -> next cycle out_valid=1, out_ts=5, out_pc=0x00400000, count=1; held until out_ready=1.
REQ-039 DEPTH=16, STOP_ON_OVF=1, 18 back-to-back commits with out_ready=0 -> count=16, overflow=1, frozen=1, drop_cnt=2; draining yields the first 16 PCs in order.
REQ-040 Full FIFO, out_ready=1 and commit_valid=1 in the same cycle -> count stays 16, no drop, new entry appears last.
REQ-041 STOP_ON_OVF=1, FROZEN, clear=1 with commit_valid=1 -> next cycle count=0, overflow=0, drop_cnt=0, frozen=0; that commit is not stored.
REQ-042 Reset driven low mid-stream with count=7 -> immediately count=0, out_valid=0; after release, the first commit gets timestamp 1 or later, per REQ-019 and REQ-037.
REQ-043 Continuous push/pop for 40 cycles with DEPTH=16 -> pointer wrap, entries emerge in order, count never exceeds 1.
